board_row_tx: RTL and testbench

Reader side of the board bus driven by clear_redraw. On a frame request it snapshots the 32-bit board_out word and streams it one row per beat to the LED/display driver over a valid/ready link, top row first. Sits between clear_redraw and the display driver in the Tetris top level. It also carries clear_redraw's error flag into the frame.

---
 rtl/tetris_pkg.sv | 25 ++
 rtl/board_row_mux.sv | 33 +++
 rtl/board_row_tx.sv | 98 +++++++++
 tb/tb_board_row_tx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types and helpers for the Tetris board path: board geometry defaults,
// row-streamer FSM state, row index type and the board-word row slicer.
package tetris_pkg;

  localparam int ROWS_DEF  = 8;
  localparam int COLS_DEF  = 4;
  localparam int ROW_IDX_W = $clog2(ROWS_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [ROW_IDX_W-1:0] row_idx_t;

  // Row r occupies bits [r*COLS+COLS-1 : r*COLS]; row ROWS-1 is the top row.
  function automatic logic [COLS_DEF-1:0] row_slice(
    input logic [ROWS_DEF*COLS_DEF-1:0] board,
    input row_idx_t                     idx
  );
    return board[int'(idx)*COLS_DEF +: COLS_DEF];
  endfunction

endpackage

// File: rtl/board_row_mux.sv
// Selects one row of the captured board word for transmission; an errored
// frame forces every cell on. Optional parity output under BOARD_ROW_TX_PARITY_EN.
module board_row_mux
  import tetris_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic [ROWS*COLS-1:0] shadow,
  input  row_idx_t             row_idx,
  input  logic                 err_frame,
  input  logic                 en,
  output logic [COLS-1:0]      row_data
`ifdef BOARD_ROW_TX_PARITY_EN
  ,
  output logic                 row_parity
`endif
);

  always_comb begin
    row_data = '0;
    if (en) begin
      if (err_frame) row_data = '1;
      else           row_data = row_slice(shadow, row_idx);
    end
  end

`ifdef BOARD_ROW_TX_PARITY_EN
  // row_data is already zero when idle, so parity follows it to zero.
  assign row_parity = ^row_data;
`endif

endmodule

// File: rtl/board_row_tx.sv
// Snapshots the clear_redraw board word on a frame request and streams it top
// row first over a valid/ready link. Optional row_parity via BOARD_ROW_TX_PARITY_EN.
module board_row_tx
  import tetris_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                 clka,
  input  logic                 restart,
  input  logic [ROWS*COLS-1:0] board_in,
  input  logic                 error_in,
  input  logic                 frame_req,
  output logic                 row_valid,
  input  logic                 row_ready,
  output row_idx_t             row_addr,
  output logic [COLS-1:0]      row_data,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 overrun
`ifdef BOARD_ROW_TX_PARITY_EN
  ,
  output logic                 row_parity
`endif
);

  state_t               state, state_nxt;
  row_idx_t             row_idx;
  logic [ROWS*COLS-1:0] shadow;
  logic                 err_frame;
  logic                 capture;
  logic                 accept;

  always_ff @(posedge clka or negedge restart) begin
    if (!restart) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        capture = frame_req;
        if (frame_req) state_nxt = SEND;
      end
      SEND: begin
        accept = row_ready;
        if (row_ready && (row_idx == '0)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot and row counter; requests outside IDLE only flag an overrun.
  always_ff @(posedge clka or negedge restart) begin
    if (!restart) begin
      shadow    <= '0;
      err_frame <= 1'b0;
      row_idx   <= '0;
      overrun   <= 1'b0;
    end else begin
      if (capture) begin
        shadow    <= board_in;
        err_frame <= error_in;
        row_idx   <= row_idx_t'(ROWS - 1);
      end else if (accept && (row_idx != '0)) begin
        row_idx <= row_idx - row_idx_t'(1);
      end
      if (frame_req && (state != IDLE)) overrun <= 1'b1;
    end
  end

  assign row_valid   = (state == SEND);
  assign row_addr    = row_valid ? row_idx : '0;
  assign frame_start = row_valid && (row_idx == row_idx_t'(ROWS - 1));
  assign frame_done  = (state == DONE);
  assign busy        = (state != IDLE);

  board_row_mux #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_mux (
    .shadow     (shadow),
    .row_idx    (row_idx),
    .err_frame  (err_frame),
    .en         (row_valid),
    .row_data   (row_data)
`ifdef BOARD_ROW_TX_PARITY_EN
    ,
    .row_parity (row_parity)
`endif
  );

endmodule

// File: tb/tb_board_row_tx.sv
// Directed bench for board_row_tx: table of whole frames plus hand-written
// backpressure, overrun and mid-frame reset sequences.
module tb_board_row_tx;

  logic        clka = 1'b0;
  logic        restart = 1'b0;
  logic [31:0] board_in = '0;
  logic        error_in = 1'b0;
  logic        frame_req = 1'b0;
  logic        row_valid;
  logic        row_ready = 1'b1;
  logic [2:0]  row_addr;
  logic [3:0]  row_data;
  logic        frame_start;
  logic        frame_done;
  logic        busy;
  logic        overrun;
`ifdef BOARD_ROW_TX_PARITY_EN
  logic        row_parity;
`endif

  int n_vec = 0;
  int n_err = 0;

  board_row_tx dut (
    .clka        (clka),
    .restart     (restart),
    .board_in    (board_in),
    .error_in    (error_in),
    .frame_req   (frame_req),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_addr    (row_addr),
    .row_data    (row_data),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy),
    .overrun     (overrun)
`ifdef BOARD_ROW_TX_PARITY_EN
    ,
    .row_parity  (row_parity)
`endif
  );

  always #5 clka = ~clka;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] board;
    logic        err;
    logic        scramble;
    logic [31:0] exp_word;
    logic [7:0]  exp_par;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clka);
    #1;
  endtask

  task automatic start_frame(input logic [31:0] b, input logic e);
    board_in  = b;
    error_in  = e;
    frame_req = 1'b1;
    step;
    frame_req = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int busy_cnt;
    row_ready = 1'b1;
    start_frame(v.board, v.err);
    busy_cnt = 0;
    if (v.scramble) begin
      board_in = 32'hFFFF_FFFF;
      error_in = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin
      int r;
      r = 7 - k;
      check("beat_valid", {31'd0, row_valid}, 32'd1);
      check("beat_addr", {29'd0, row_addr}, r);
      check("beat_data", {28'd0, row_data}, {28'd0, v.exp_word[r*4 +: 4]});
      check("frame_start", {31'd0, frame_start}, (k == 0) ? 32'd1 : 32'd0);
`ifdef BOARD_ROW_TX_PARITY_EN
      check("row_parity", {31'd0, row_parity}, {31'd0, v.exp_par[r]});
`endif
      if (busy) busy_cnt++;
      step;
    end
    check("done_pulse", {31'd0, frame_done}, 32'd1);
    check("done_valid", {31'd0, row_valid}, 32'd0);
    check("done_data", {28'd0, row_data}, 32'd0);
    if (busy) busy_cnt++;
    step;
    check("done_clear", {31'd0, frame_done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("busy_len", busy_cnt, 32'd9);
    board_in = '0;
    error_in = 1'b0;
  endtask

  initial begin
    int beats;
    int stalls;
    int cyc;

    vecs[0] = '{32'h2000_0000, 1'b0, 1'b0, 32'h2000_0000, 8'h80};
    vecs[1] = '{32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 8'hD3};
    vecs[2] = '{32'hA5A5_A5A5, 1'b1, 1'b0, 32'hFFFF_FFFF, 8'h00};
    vecs[3] = '{32'h0000_000F, 1'b0, 1'b1, 32'h0000_000F, 8'h00};
    vecs[4] = '{32'h8421_0000, 1'b0, 1'b0, 32'h8421_0000, 8'hF0};

    // Reset held with a request pending: nothing may start.
    restart   = 1'b0;
    frame_req = 1'b1;
    board_in  = 32'hFFFF_FFFF;
    step;
    step;
    check("rst_valid", {31'd0, row_valid}, 32'd0);
    check("rst_addr", {29'd0, row_addr}, 32'd0);
    check("rst_data", {28'd0, row_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_start", {31'd0, frame_start}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    frame_req = 1'b0;
    board_in  = '0;
    restart   = 1'b1;
    step;
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i]);
      step;
    end
    check("no_overrun_yet", {31'd0, overrun}, 32'd0);

    // Backpressure: stall three cycles on row 5.
    start_frame(32'h1234_5678, 1'b0);
    beats  = 0;
    stalls = 0;
    cyc    = 0;
    while (beats < 8 && cyc < 40) begin
      if (row_valid && row_addr == 3'd5 && stalls < 3) begin
        row_ready = 1'b0;
        check("bp_hold_addr", {29'd0, row_addr}, 32'd5);
        check("bp_hold_data", {28'd0, row_data}, 32'h3);
        stalls++;
      end else begin
        row_ready = 1'b1;
        check("bp_addr", {29'd0, row_addr}, 32'(7 - beats));
        if (row_valid) beats++;
      end
      step;
      cyc++;
    end
    row_ready = 1'b1;
    check("bp_beats", beats, 32'd8);
    check("bp_stalls", stalls, 32'd3);
    check("bp_done", {31'd0, frame_done}, 32'd1);
    step;
    step;

    // Overrun: request lands while row 3 is on the link.
    start_frame(32'h2000_0000, 1'b0);
    for (int k = 0; k < 8 && row_valid; k++) begin
      frame_req = (row_addr == 3'd3);
      step;
      frame_req = 1'b0;
    end
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_done", {31'd0, frame_done}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step;
      check("ovr_no_frame", {31'd0, busy}, 32'd0);
      check("ovr_sticky", {31'd0, overrun}, 32'd1);
    end

    // Mid-frame reset on row 3.
    start_frame(32'h1234_5678, 1'b0);
    for (int k = 0; k < 4; k++) step;
    check("mr_addr", {29'd0, row_addr}, 32'd3);
    restart = 1'b0;
    #1;
    check("mr_valid_drop", {31'd0, row_valid}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_data", {28'd0, row_data}, 32'd0);
    check("mr_ovr_clear", {31'd0, overrun}, 32'd0);
    step;
    restart = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      check("mr_no_done", {31'd0, frame_done}, 32'd0);
      check("mr_idle", {31'd0, busy}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
